// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared game constants, FSM encoding and index helpers for the enemy fire scheduler.
// The wave layout (COLUNAS x LINHAS) lives here so every block agrees on the bitmap shape.
package enemy_fire_scheduler_pkg;

  localparam int unsigned COLUNAS = 13;
  localparam int unsigned LINHAS  = 5;

  localparam int unsigned IdxW = 7;
  localparam int unsigned RowW = 3;
  localparam int unsigned ColW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StPick,
    StScan,
    StFire
  } state_e;

  // Flat bitmap position of an enemy, computed at index width.
  function automatic logic [IdxW-1:0] flat_idx(input logic [RowW-1:0] row,
                                               input logic [ColW-1:0] col,
                                               input int unsigned     cols);
    return IdxW'(row) * IdxW'(cols) + IdxW'(col);
  endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Game-side handshake between the enemy wave and the enemy fire scheduler.
// master is the scheduler; slave is the game logic that owns the bullet and the wave.
interface enemy_fire_scheduler_if #(
  parameter int unsigned NumInimigos = 65
);
  import enemy_fire_scheduler_pkg::*;

  logic                   enable;
  logic [NumInimigos-1:0] vivo_inimigo;
  logic                   tiro_livre;
  logic                   disparo;
  logic [IdxW-1:0]        ID_enemy_tiro_X;
  logic [RowW-1:0]        ID_enemy_tiro_Y;
  logic                   ocupado;

  modport master (
    input  enable,
    input  vivo_inimigo,
    input  tiro_livre,
    output disparo,
    output ID_enemy_tiro_X,
    output ID_enemy_tiro_Y,
    output ocupado
  );

  modport slave (
    output enable,
    output vivo_inimigo,
    output tiro_livre,
    input  disparo,
    input  ID_enemy_tiro_X,
    input  ID_enemy_tiro_Y,
    input  ocupado
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, used to randomise the shooter column.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  localparam logic [15:0] Taps = 16'hB400;

  // A zero seed would lock the register, so fall back to a non-zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= (seed != 16'h0000) ? seed : 16'h0001;
    end else begin
      q <= (q >> 1) ^ (q[0] ? Taps : 16'h0000);
    end
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Periodically picks a random column, scans it bottom-up for a live enemy and fires once the
// enemy bullet is free; gives up after every column has been tried once.
module enemy_fire_scheduler #(
  parameter int unsigned COLUNAS   = enemy_fire_scheduler_pkg::COLUNAS,
  parameter int unsigned LINHAS    = enemy_fire_scheduler_pkg::LINHAS,
  parameter int unsigned PERIODO   = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  enemy_fire_scheduler_if.master        bus
);
  import enemy_fire_scheduler_pkg::*;

  localparam int unsigned TimerW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(PERIODO - 1);
  localparam int unsigned TriedW = ColW + 1;

  logic [15:0]       lfsr_q;
  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [ColW-1:0]   col_q, lat_col_q;
  logic [RowW-1:0]   row_q, lat_row_q;
  logic [TriedW-1:0] tried_q;
  logic              disparo_q, ocupado_q;
  logic [IdxW-1:0]   id_x_q;
  logic [RowW-1:0]   id_y_q;

  logic [ColW-1:0]   lfsr_col, pick_col;
  logic [IdxW-1:0]   scan_idx, lat_idx;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:ColW];
  assign lfsr_col    = lfsr_q[ColW-1:0];

  // Fold the 4-bit random value into 0..COLUNAS-1 with a single subtraction.
  always_comb begin
    pick_col = lfsr_col;
    if (lfsr_col >= ColW'(COLUNAS)) begin
      pick_col = lfsr_col - ColW'(COLUNAS);
    end
  end

  assign scan_idx = flat_idx(row_q, col_q, COLUNAS);
  assign lat_idx  = flat_idx(lat_row_q, lat_col_q, COLUNAS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= TimerLoad;
      col_q     <= '0;
      row_q     <= '0;
      tried_q   <= '0;
      lat_col_q <= '0;
      lat_row_q <= '0;
      disparo_q <= 1'b0;
      ocupado_q <= 1'b0;
      id_x_q    <= '0;
      id_y_q    <= '0;
    end else if (!bus.enable) begin
      state_q   <= StIdle;
      timer_q   <= TimerLoad;
      disparo_q <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      disparo_q <= 1'b0;
      case (state_q)
        StIdle: begin
          state_q <= StWait;
          timer_q <= TimerLoad;
        end
        StWait: begin
          if (timer_q == '0) begin
            state_q   <= StPick;
            ocupado_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StPick: begin
          col_q   <= pick_col;
          row_q   <= RowW'(LINHAS - 1);
          tried_q <= '0;
          state_q <= StScan;
        end
        StScan: begin
          if (bus.vivo_inimigo[scan_idx]) begin
            lat_col_q <= col_q;
            lat_row_q <= row_q;
            state_q   <= StFire;
          end else if (row_q != '0) begin
            row_q <= row_q - RowW'(1);
          end else if (tried_q == TriedW'(COLUNAS - 1)) begin
            // Every column exhausted: abandon this attempt quietly.
            state_q   <= StWait;
            timer_q   <= TimerLoad;
            ocupado_q <= 1'b0;
          end else begin
            col_q   <= (col_q == ColW'(COLUNAS - 1)) ? '0 : col_q + ColW'(1);
            row_q   <= RowW'(LINHAS - 1);
            tried_q <= tried_q + TriedW'(1);
          end
        end
        StFire: begin
          if (!bus.vivo_inimigo[lat_idx]) begin
            state_q <= StPick;
          end else if (bus.tiro_livre) begin
            disparo_q <= 1'b1;
            id_x_q    <= lat_idx;
            id_y_q    <= lat_row_q;
            ocupado_q <= 1'b0;
            timer_q   <= TimerLoad;
            state_q   <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.disparo         = disparo_q;
  assign bus.ocupado         = ocupado_q;
  assign bus.ID_enemy_tiro_X = id_x_q;
  assign bus.ID_enemy_tiro_Y = id_y_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with PERIODO=8: single-target vector table plus
// hand-written sequences for busy hold, target loss, enable drop, empty wave and reset.
module tb_enemy_fire_scheduler;

  localparam int unsigned Cols   = 13;
  localparam int unsigned Rows   = 5;
  localparam int unsigned N      = Cols * Rows;
  localparam int          NumVec = 6;

  typedef struct {
    logic [N-1:0] vivo;
    logic [6:0]   exp_x;
    logic [2:0]   exp_y;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NumVec];

  always #5 clk = ~clk;

  enemy_fire_scheduler_if #(.NumInimigos(N)) bus ();

  enemy_fire_scheduler #(
    .COLUNAS   (Cols),
    .LINHAS    (Rows),
    .PERIODO   (8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_fire(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.disparo === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.ocupado === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad;
    int rises;
    int falls;
    int pulse_len;
    int fires;
    logic prev_busy;
    logic first_done;

    // Single live enemies (or one column) give a shooter independent of the random column.
    vecs[0] = '{vivo: 65'd1 << 3,  exp_x: 7'd3,  exp_y: 3'd0};
    vecs[1] = '{vivo: 65'd1 << 64, exp_x: 7'd64, exp_y: 3'd4};
    vecs[2] = '{vivo: 65'd1 << 26, exp_x: 7'd26, exp_y: 3'd2};
    vecs[3] = '{vivo: 65'd1 << 46, exp_x: 7'd46, exp_y: 3'd3};
    vecs[4] = '{vivo: 65'd1 << 25, exp_x: 7'd25, exp_y: 3'd1};
    vecs[5] = '{vivo: (65'd1 << 18) | (65'd1 << 44), exp_x: 7'd44, exp_y: 3'd3};

    // Reset wins over a high enable.
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.vivo_inimigo = '1;
    bus.tiro_livre   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_disparo", bus.disparo, 0);
    check("rst_ocupado", bus.ocupado, 0);
    check("rst_id_x", bus.ID_enemy_tiro_X, 0);
    check("rst_id_y", bus.ID_enemy_tiro_Y, 0);
    reset = 1'b0;

    // IDLE->WAIT, 8 WAIT, 1 PICK, 1 SCAN (bottom row alive), 1 FIRE, then the strobe.
    wait_fire(40, n);
    check("all_alive_latency", n, 12);
    check("all_alive_y", bus.ID_enemy_tiro_Y, 4);
    check("all_alive_x_range", (bus.ID_enemy_tiro_X >= 52 && bus.ID_enemy_tiro_X <= 64), 1);
    check("all_alive_ocupado_drop", bus.ocupado, 0);
    @(negedge clk);
    check("all_alive_one_cycle", bus.disparo, 0);

    for (int v = 0; v < NumVec; v++) begin
      do_reset();
      bus.vivo_inimigo = vecs[v].vivo;
      bus.tiro_livre   = 1'b1;
      bus.enable       = 1'b1;
      wait_fire(90, n);
      check($sformatf("vec%0d_first_window", v), (n >= 12 && n <= 76), 1);
      check($sformatf("vec%0d_first_x", v), bus.ID_enemy_tiro_X, vecs[v].exp_x);
      check($sformatf("vec%0d_first_y", v), bus.ID_enemy_tiro_Y, vecs[v].exp_y);
      @(negedge clk);
      check($sformatf("vec%0d_one_cycle", v), bus.disparo, 0);
      wait_fire(90, n);
      check($sformatf("vec%0d_second_window", v), (n >= 10 && n <= 74), 1);
      check($sformatf("vec%0d_second_x", v), bus.ID_enemy_tiro_X, vecs[v].exp_x);
      check($sformatf("vec%0d_second_y", v), bus.ID_enemy_tiro_Y, vecs[v].exp_y);
    end

    // Bullet busy: sit in FIRE for 50 cycles, then release exactly one shot.
    bus.tiro_livre = 1'b0;
    wait_busy(20, n);
    check("hold_busy_seen", (n > 0), 1);
    repeat (70) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.disparo !== 1'b0 || bus.ocupado !== 1'b1) bad++;
    end
    check("hold_no_fire_busy", bad, 0);
    bus.tiro_livre = 1'b1;
    @(negedge clk);
    check("hold_release_disparo", bus.disparo, 1);
    check("hold_release_x", bus.ID_enemy_tiro_X, 44);
    @(negedge clk);
    check("hold_release_one_cycle", bus.disparo, 0);

    // Target killed while waiting in FIRE: the other enemy in the column is shot instead.
    bus.tiro_livre = 1'b0;
    wait_busy(20, n);
    repeat (70) @(negedge clk);
    bus.vivo_inimigo = 65'd1 << 18;
    bus.tiro_livre   = 1'b1;
    wait_fire(80, n);
    check("retarget_fired", (n > 0), 1);
    check("retarget_x", bus.ID_enemy_tiro_X, 18);
    check("retarget_y", bus.ID_enemy_tiro_Y, 1);

    // Enable dropped mid-FIRE: outputs quiet, IDs held, timer restarted from IDLE.
    bus.tiro_livre = 1'b0;
    wait_busy(20, n);
    repeat (70) @(negedge clk);
    check("en_drop_pre_busy", bus.ocupado, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("en_drop_disparo", bus.disparo, 0);
    check("en_drop_ocupado", bus.ocupado, 0);
    check("en_drop_x_held", bus.ID_enemy_tiro_X, 18);
    check("en_drop_y_held", bus.ID_enemy_tiro_Y, 1);
    bus.vivo_inimigo = '1;
    bus.tiro_livre   = 1'b1;
    bus.enable       = 1'b1;
    wait_fire(40, n);
    check("en_restart_latency", n, 12);
    check("en_restart_y", bus.ID_enemy_tiro_Y, 4);

    // Empty wave: attempts of 74 cycles, busy for PICK plus 65 SCAN cycles, never a shot.
    bus.vivo_inimigo = '0;
    rises      = 0;
    falls      = 0;
    pulse_len  = 0;
    fires      = 0;
    prev_busy  = bus.ocupado;
    first_done = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.disparo === 1'b1) fires++;
      if (bus.ocupado === 1'b1 && prev_busy === 1'b0) rises++;
      if (bus.ocupado === 1'b0 && prev_busy === 1'b1) begin
        falls++;
        first_done = 1'b1;
      end
      if (bus.ocupado === 1'b1 && !first_done) pulse_len++;
      prev_busy = bus.ocupado;
    end
    check("empty_no_fire", fires, 0);
    check("empty_busy_rises", rises, 3);
    check("empty_busy_falls", falls, 2);
    check("empty_first_pulse_len", pulse_len, 66);

    // Reset in the middle of the third search.
    check("rst_scan_pre_busy", bus.ocupado, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_scan_disparo", bus.disparo, 0);
    check("rst_scan_ocupado", bus.ocupado, 0);
    check("rst_scan_id_x", bus.ID_enemy_tiro_X, 0);
    check("rst_scan_id_y", bus.ID_enemy_tiro_Y, 0);
    reset      = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
